key_input: RTL and testbench
============================

# key_input

Debounced reader for the active-low player push-buttons: the input-side counterpart of the active-low RGB LED drive in the reaction-time tester. Synchronises each raw key, filters contact bounce with a per-key counter FSM, and presents a clean level plus single-cycle press, release and optional long-press pulses to the game controller. One instance serves all player keys; channels are fully independent.

## Interface
- N_KEYS, 2, number of independent key channels
- DEB_CYCLES, 1_000_000, consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz); must be ≥ 1
- LONG_CYCLES, 50_000_000, cycles in HELD before the long-press pulse fires (1 s at 50 MHz); must be > DEB_CYCLES
- clk  input  1  system clock, single clock domain
- rstn  input  1  asynchronous active-low reset
- key_n  input  N_KEYS  raw button pins, 0 = pressed, asynchronous to clk
- key_level  output  N_KEYS  debounced level, 1 = pressed
- key_press  output  N_KEYS  one-cycle pulse on accepted press
- key_release  output  N_KEYS  one-cycle pulse on accepted release
- key_long  output  N_KEYS  one-cycle pulse on long press (see Configuration)

## Operation
- Reset: all outputs 0; synchroniser flops reset to 1 (released); every channel in IDLE; counters 0.
- Per channel: 2-flop synchroniser on key_n, inverted to active-high `s`.
- FSM states: IDLE (released, stable), PRESS_WAIT, HELD (pressed, stable), RELEASE_WAIT.
- IDLE: s=1 → PRESS_WAIT, counter loads 1.
- PRESS_WAIT: s=1 and counter = DEB_CYCLES → HELD, key_level←1, key_press pulse; s=1 otherwise → counter+1; s=0 → IDLE, counter 0, no pulse.
- HELD: s=0 → RELEASE_WAIT, counter loads 1; long counter runs while in HELD or RELEASE_WAIT.
- RELEASE_WAIT: s=0 and counter = DEB_CYCLES → IDLE, key_level←0, key_release pulse, long counter cleared; s=1 → HELD, counter 0 (bounce rejected, long counter keeps running).
- DEB_CYCLES = 1: transition accepted on first differing sample.
- Counter width $clog2(LONG_CYCLES+1); counters saturate, never wrap.
- Key held through reset deassertion: treated as a fresh press; key_press fires after the normal debounce latency.
- Reset asserted mid-debounce or mid-hold: immediate return to reset state, no pulse emitted.
- Pulses are registered; press and release can never coincide on one channel; different channels may pulse in the same cycle.

## Timing
- Edge 0 = first clk edge sampling key_n low; s changes after edge 1; key_press and key_level high after edge DEB_CYCLES+1; key_press low again after edge DEB_CYCLES+2.
- Release latency identical to press latency.
- Any bounce shorter than DEB_CYCLES synchronised cycles produces no output change.
- key_long: high for exactly one cycle when long counter reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after key_press; at most once per press.

## Configuration
- KEY_LONG_PRESS_EN defined: long counter and key_long logic built per channel as above.
- Undefined: key_long driven constant 0, long counter not instantiated; all other behaviour unchanged.

## Structure
- Shared package key_pkg: FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and default DEB_CYCLES/LONG_CYCLES constants.
- Sub-module key_debounce_ch: one channel (synchroniser, FSM, counters); top generates N_KEYS instances and concatenates outputs.

## Test plan
- Bench DEB_CYCLES=4, LONG_CYCLES=16. Clean press, key_n[0] low from edge 0 → key_press[0] single pulse after edge 5, key_level[0]=1.
- Bounce: key_n[0] low 3 cycles, high 1, low 3, high → no pulses, key_level stays 0.
- Clean release after press, with one 2-cycle glitch mid-release → key_release one pulse 5 edges after final stable high, none for glitch.
- Hold key 0 for 30 cycles (macro defined) → exactly one key_long[0] pulse 16 cycles after key_press; undefined → key_long stays 0.
- Keys 0 and 1 pressed on same edge → key_press = 2'b11 for one cycle.
- rstn low during PRESS_WAIT with key held, then released (rstn high) → all outputs 0 in reset; key_press fires 5 edges after rstn deassert.

Source files
------------

// File: rtl/key_pkg.sv
// Shared FSM state type and default timing for the debounced key reader.
// Default counts assume a 50 MHz clock (20 ms debounce, 1 s long press).
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } key_state_e;

   localparam int DEB_CYCLES_DEF  = 1_000_000;
   localparam int LONG_CYCLES_DEF = 50_000_000;

   function automatic int cnt_width(input int long_cycles);
      return $clog2(long_cycles + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, optional long-press counter (KEY_LONG_PRESS_EN).
// Latency: level/pulses registered DEB_CYCLES+2 clk after the pin settles; no backpressure, pulses are fire-and-forget.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int            CW       = cnt_width(LONG_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam bit            DEB_ONE  = (DEB_CYCLES == 1);

   logic [1:0]    sync_q;
   key_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic          s;

`ifdef KEY_LONG_PRESS_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);

   logic [CW-1:0] lcnt_q;
   logic          long_q;
`endif

   assign s = ~sync_q[1];

   // cnt_q counts stable samples already seen, so the current sample completes the window at DEB_LAST.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q    <= 2'b11;
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
         lcnt_q    <= '0;
         long_q    <= 1'b0;
`endif
      end else begin
         sync_q    <= {sync_q[0], key_n};
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
         long_q <= 1'b0;
         if ((state_q == HELD || state_q == RELEASE_WAIT) && lcnt_q != LONG_MAX) begin
            lcnt_q <= lcnt_q + CNT_ONE;
            if (lcnt_q == LONG_LAST) long_q <= 1'b1;
         end
`endif
         unique case (state_q)
            IDLE: begin
               if (s) begin
                  if (DEB_ONE) begin
                     state_q <= HELD;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= PRESS_WAIT;
                     cnt_q   <= CNT_ONE;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q >= DEB_LAST) begin
                  state_q <= HELD;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            HELD: begin
               if (!s) begin
                  if (DEB_ONE) begin
                     state_q   <= IDLE;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                     cnt_q     <= '0;
`ifdef KEY_LONG_PRESS_EN
                     lcnt_q    <= '0;
`endif
                  end else begin
                     state_q <= RELEASE_WAIT;
                     cnt_q   <= CNT_ONE;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_q >= DEB_LAST) begin
                  state_q   <= IDLE;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
                  cnt_q     <= '0;
`ifdef KEY_LONG_PRESS_EN
                  lcnt_q    <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
`ifdef KEY_LONG_PRESS_EN
   assign key_long    = long_q;
`else
   assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_input.sv
// key_input: N_KEYS independent debounced readers for active-low push-buttons; KEY_LONG_PRESS_EN adds long-press pulses.
// Latency: DEB_CYCLES+2 clk from settled pin to level/pulse; no backpressure, pulses are single-cycle and unacknowledged.
module key_input
   import key_pkg::*;
#(
   parameter int N_KEYS      = 2,
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYCLES  (DEB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rstn        (rstn),
         .key_n       (key_n[g]),
         .key_level   (key_level[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g]),
         .key_long    (key_long[g])
      );
   end

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: directed scenarios plus randomized bouncing against a sliding-window model.
module tb_key_input;

   localparam int N    = 2;
   localparam int DEB  = 4;
   localparam int LONG = 16;

   logic         clk;
   logic         rstn;
   logic [N-1:0] key_n;
   logic [N-1:0] key_level;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;
   logic [N-1:0] key_long;

   int n_checks = 0;
   int n_pass   = 0;

   key_input #(
      .N_KEYS      (N),
      .DEB_CYCLES  (DEB),
      .LONG_CYCLES (LONG)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: level flips once the last DEB synchronised samples all disagree with it.
   logic [7:0]   m_pins [N];
   logic [7:0]   m_win  [N];
   int           press_at [N];
   int           cyc = 0;
   logic [N-1:0] exp_level = '0;
   logic [N-1:0] exp_press = '0;
   logic [N-1:0] exp_rel   = '0;
   logic [N-1:0] exp_long  = '0;

   initial begin
      for (int i = 0; i < N; i++) begin
         m_pins[i]   = '1;
         m_win[i]    = '0;
         press_at[i] = 0;
      end
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            for (int i = 0; i < N; i++) begin
               m_pins[i] = '1;
               m_win[i]  = '0;
            end
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
            exp_long  = '0;
         end else begin
            cyc++;
            for (int i = 0; i < N; i++) begin
               logic           samp;
               logic           was_on;
               logic [DEB-1:0] w;
               samp      = ~m_pins[i][1];
               m_pins[i] = {m_pins[i][6:0], key_n[i]};
               m_win[i]  = {m_win[i][6:0], samp};
               w         = m_win[i][DEB-1:0];
               was_on    = exp_level[i];
               exp_press[i] = 1'b0;
               exp_rel[i]   = 1'b0;
               exp_long[i]  = 1'b0;
`ifdef KEY_LONG_PRESS_EN
               if (was_on && (cyc - press_at[i]) == LONG) exp_long[i] = 1'b1;
`endif
               if (!was_on && w == {DEB{1'b1}}) begin
                  exp_level[i] = 1'b1;
                  exp_press[i] = 1'b1;
                  press_at[i]  = cyc;
               end else if (was_on && w == '0) begin
                  exp_level[i] = 1'b0;
                  exp_rel[i]   = 1'b1;
               end
            end
         end
      end
   end

   task automatic settle();
      key_n = '1;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn  = 1'b0;
      key_n = '1;
      repeat (3) @(negedge clk);
      n_checks++; if (key_level !== '0) $display("FAIL reset_level: got %b want 00", key_level); else n_pass++;
      n_checks++; if (key_press !== '0) $display("FAIL reset_press: got %b want 00", key_press); else n_pass++;
      n_checks++; if (key_release !== '0) $display("FAIL reset_release: got %b want 00", key_release); else n_pass++;
      n_checks++; if (key_long !== '0) $display("FAIL reset_long: got %b want 00", key_long); else n_pass++;
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if ({key_level, key_press, key_release, key_long} !== '0)
         $display("FAIL idle_after_reset: got %b want 0", {key_level, key_press, key_release, key_long});
      else n_pass++;
   endtask

   task automatic test_press();
      int np = 0;
      int at = -1;
      key_n[0] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_checks++;
         if ({key_level, key_press, key_release, key_long} !== {exp_level, exp_press, exp_rel, exp_long})
            $display("FAIL press_model c=%0d: got %b want %b", c,
                     {key_level, key_press, key_release, key_long}, {exp_level, exp_press, exp_rel, exp_long});
         else n_pass++;
         if (key_press[0]) begin np++; at = c; end
      end
      n_checks++; if (np != 1) $display("FAIL press_count: got %0d want 1", np); else n_pass++;
      n_checks++; if (at != 5) $display("FAIL press_edge: got %0d want 5", at); else n_pass++;
      n_checks++; if (key_level[0] !== 1'b1) $display("FAIL press_level: got %b want 1", key_level[0]); else n_pass++;
      settle();
   endtask

   task automatic test_bounce();
      logic [0:15] pat;
      int np = 0;
      int nr = 0;
      int nl = 0;
      pat = 16'b0001000111111111;
      for (int c = 0; c < 16; c++) begin
         key_n[0] = pat[c];
         @(negedge clk);
         n_checks++;
         if ({key_level, key_press, key_release} !== {exp_level, exp_press, exp_rel})
            $display("FAIL bounce_model c=%0d: got %b want %b", c,
                     {key_level, key_press, key_release}, {exp_level, exp_press, exp_rel});
         else n_pass++;
         if (key_press[0]) np++;
         if (key_release[0]) nr++;
         if (key_level[0]) nl++;
      end
      n_checks++; if (np != 0) $display("FAIL bounce_press: got %0d want 0", np); else n_pass++;
      n_checks++; if (nr != 0) $display("FAIL bounce_release: got %0d want 0", nr); else n_pass++;
      n_checks++; if (nl != 0) $display("FAIL bounce_level: got %0d cycles high want 0", nl); else n_pass++;
      settle();
   endtask

   task automatic test_release_glitch();
      logic [0:11] pat;
      int nr = 0;
      int at = -1;
      pat = 12'b110011111111;
      key_n[0] = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++; if (key_level[0] !== 1'b1) $display("FAIL glitch_pre_level: got %b want 1", key_level[0]); else n_pass++;
      for (int c = 0; c < 12; c++) begin
         key_n[0] = pat[c];
         @(negedge clk);
         n_checks++;
         if ({key_level, key_press, key_release, key_long} !== {exp_level, exp_press, exp_rel, exp_long})
            $display("FAIL glitch_model c=%0d: got %b want %b", c,
                     {key_level, key_press, key_release, key_long}, {exp_level, exp_press, exp_rel, exp_long});
         else n_pass++;
         if (key_release[0]) begin nr++; at = c; end
      end
      n_checks++; if (nr != 1) $display("FAIL glitch_rel_count: got %0d want 1", nr); else n_pass++;
      n_checks++; if (at != 9) $display("FAIL glitch_rel_edge: got %0d want 9", at); else n_pass++;
      settle();
   endtask

   task automatic test_long();
      int nl = 0;
      int at = -1;
      int pa = -1;
      key_n[0] = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_checks++;
         if ({key_level, key_press, key_release, key_long} !== {exp_level, exp_press, exp_rel, exp_long})
            $display("FAIL long_model c=%0d: got %b want %b", c,
                     {key_level, key_press, key_release, key_long}, {exp_level, exp_press, exp_rel, exp_long});
         else n_pass++;
         if (key_press[0]) pa = c;
         if (key_long[0]) begin nl++; at = c; end
      end
      n_checks++; if (pa != 5) $display("FAIL long_press_edge: got %0d want 5", pa); else n_pass++;
`ifdef KEY_LONG_PRESS_EN
      n_checks++; if (nl != 1) $display("FAIL long_count: got %0d want 1", nl); else n_pass++;
      n_checks++; if (at != 5 + LONG) $display("FAIL long_edge: got %0d want %0d", at, 5 + LONG); else n_pass++;
`else
      n_checks++; if (nl != 0) $display("FAIL long_disabled: got %0d pulses (last %0d) want 0", nl, at); else n_pass++;
`endif
      settle();
   endtask

   task automatic test_both();
      key_n = 2'b00;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 4 || c == 6) begin
            n_checks++; if (key_press !== 2'b00) $display("FAIL both_quiet c=%0d: got %b want 00", c, key_press); else n_pass++;
         end
         if (c == 5) begin
            n_checks++; if (key_press !== 2'b11) $display("FAIL both_press: got %b want 11", key_press); else n_pass++;
         end
      end
      n_checks++; if (key_level !== 2'b11) $display("FAIL both_level: got %b want 11", key_level); else n_pass++;
      settle();
   endtask

   task automatic test_reset_mid();
      int at = -1;
      key_n[0] = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({key_level, key_press, key_release, key_long} !== '0)
         $display("FAIL rst_debounce: got %b want 0", {key_level, key_press, key_release, key_long});
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      n_checks++; if (key_level[0] !== 1'b1) $display("FAIL rst_hold_pre: got %b want 1", key_level[0]); else n_pass++;
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({key_level, key_press, key_release, key_long} !== '0)
         $display("FAIL rst_hold: got %b want 0", {key_level, key_press, key_release, key_long});
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (key_press[0] && at < 0) at = c;
      end
      n_checks++; if (at != 5) $display("FAIL rst_repress_edge: got %0d want 5", at); else n_pass++;
      settle();
   endtask

   task automatic test_random();
      int   remain [N];
      logic cur    [N];
      for (int i = 0; i < N; i++) begin remain[i] = 0; cur[i] = 1'b1; end
      for (int c = 0; c < 1500; c++) begin
         rstn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < N; i++) begin
            if (remain[i] == 0) begin
               cur[i]    = 1'($urandom_range(0, 1));
               remain[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 40) : $urandom_range(1, 4);
            end
            key_n[i] = cur[i];
            remain[i]--;
         end
         @(negedge clk);
         n_checks++; if (key_level !== exp_level) $display("FAIL rnd_level c=%0d: got %b want %b", c, key_level, exp_level); else n_pass++;
         n_checks++; if (key_press !== exp_press) $display("FAIL rnd_press c=%0d: got %b want %b", c, key_press, exp_press); else n_pass++;
         n_checks++; if (key_release !== exp_rel) $display("FAIL rnd_release c=%0d: got %b want %b", c, key_release, exp_rel); else n_pass++;
         n_checks++; if (key_long !== exp_long) $display("FAIL rnd_long c=%0d: got %b want %b", c, key_long, exp_long); else n_pass++;
         n_checks++; if ((key_press & key_release) !== '0) $display("FAIL rnd_coincide c=%0d: got %b want 00", c, key_press & key_release); else n_pass++;
      end
      rstn = 1'b1;
      settle();
   endtask

   initial begin
      rstn  = 1'b0;
      key_n = '1;
      test_reset();
      test_press();
      test_bounce();
      test_release_glitch();
      test_long();
      test_both();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
